// File: rtl/vga_timing_gen_pkg.sv
// Shared raster geometry for the timing generator and the draw stages.
// Default 1024x768 @ 60 Hz on a 65 MHz pixel clock.
package vga_pkg;
  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [CNT_W-1:0] cnt_t;

  // Half-open window test lo <= v < hi.
  function automatic logic in_window(cnt_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: one pixel position plus its decoded sync/blank flags.
interface vga_timing_gen_if;
  import vga_pkg::*;

  cnt_t hcount_out;
  cnt_t vcount_out;
  logic hsync_out;
  logic vsync_out;
  logic hblnk_out;
  logic vblnk_out;
  logic frame_start;

  modport master (output hcount_out, vcount_out, hsync_out, vsync_out,
                         hblnk_out, vblnk_out, frame_start);
  modport slave  (input  hcount_out, vcount_out, hsync_out, vsync_out,
                         hblnk_out, vblnk_out, frame_start);
endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter with sync/blank decoded from the next count,
// so count, sync and blank always describe the same position.
module vga_axis_timing
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic pclk,
  input  logic rst,
  input  logic step,
  output cnt_t count,
  output logic sync,
  output logic blank,
  output logic wrap
);
  localparam int   TOTAL = ACTIVE + FP + SYNC + BP;
  localparam cnt_t LAST  = cnt_t'(TOTAL - 1);

  if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_bad_total
    $error("vga_axis_timing: TOTAL=%0d does not fit the %0d-bit counter", TOTAL, CNT_W);
  end

  cnt_t nxt;

  // High on the cycle whose edge takes the counter from LAST back to 0.
  assign wrap = step && (count == LAST);

  always_comb begin
    nxt = count;
    if (wrap)      nxt = '0;
    else if (step) nxt = count + cnt_t'(1);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count <= '0;
      sync  <= 1'b0;
      blank <= 1'b0;
    end else begin
      count <= nxt;
      sync  <= in_window(nxt, ACTIVE + FP, ACTIVE + FP + SYNC);
      blank <= in_window(nxt, ACTIVE, TOTAL);
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: horizontal and vertical axes chained on the line wrap,
// plus a frame_start strobe registered alongside the (0,0) position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);
  cnt_t hc, vc;
  logic hs, vs, hb, vb;
  logic h_wrap, v_wrap;
  logic fs;

  vga_axis_timing #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .pclk(pclk), .rst(rst), .step(1'b1),
    .count(hc), .sync(hs), .blank(hb), .wrap(h_wrap)
  );

  vga_axis_timing #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .pclk(pclk), .rst(rst), .step(h_wrap),
    .count(vc), .sync(vs), .blank(vb), .wrap(v_wrap)
  );

  // v_wrap already implies h_wrap: both axes return to 0 on this edge.
  always_ff @(posedge pclk) begin
    if (rst) fs <= 1'b0;
    else     fs <= v_wrap;
  end

  assign bus.hcount_out  = hc;
  assign bus.vcount_out  = vc;
  assign bus.hsync_out   = hs;
  assign bus.vsync_out   = vs;
  assign bus.hblnk_out   = hb;
  assign bus.vblnk_out   = vb;
  assign bus.frame_start = fs;
endmodule
